// File: rtl/decode_stage_pkg.sv
// Shared encodings for the RV32I decode stage: opcodes, instruction formats and
// the control-field codes consumed by execute, memory and write-back.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

  // Alu_code = {mode select, operation}.
  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_NEG_B = 2'd1;
  localparam logic [1:0] SEL_UNS   = 2'd2;
  localparam logic [1:0] SEL_ARITH = 2'd3;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SLL  = 3'd1;
  localparam logic [2:0] ALU_COMP = 3'd2;
  localparam logic [2:0] ALU_XOR  = 3'd3;
  localparam logic [2:0] ALU_SR   = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_AND  = 3'd6;

  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE} br_t;
  typedef enum logic [1:0] {WR_OFF, WR_B, WR_H, WR_W} wr_t;
  typedef enum logic [2:0] {RD_NONE, RD_B, RD_H, RD_W, RD_BU, RD_HU} rd_sel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;

  localparam logic SRC1_PC  = 1'b1;
  localparam logic SRC2_IMM = 1'b1;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    br_t        if_branch;
    logic       if_jump;
    logic [4:0] alu_code;
    wr_t        mem_we;
    rd_sel_t    mem_rd_sel;
    wb_sel_t    mem_out_sel;
    logic       wb_en;
    logic       alu_src1_sel;
    logic       alu_src2_sel;
    logic       illegal;
  } ctrl_t;

  // alt marks the Func7=0100000 variants (SUB, SRA/SRAI).
  function automatic logic [4:0] alu_code_of(input logic [2:0] func3, input logic alt);
    logic [1:0] sel;
    logic [2:0] op;
    case (func3)
      3'b000:         op = ALU_ADD;
      3'b001:         op = ALU_SLL;
      3'b010, 3'b011: op = ALU_COMP;
      3'b100:         op = ALU_XOR;
      3'b101:         op = ALU_SR;
      3'b110:         op = ALU_OR;
      default:        op = ALU_AND;
    endcase
    if (alt) sel = (func3 == 3'b000) ? SEL_NEG_B : SEL_ARITH;
    else     sel = (func3 == 3'b011) ? SEL_UNS : SEL_NONE;
    return {sel, op};
  endfunction

endpackage

// File: rtl/decode_core.sv
// Combinational RV32I decoder: raw instruction word to control fields and the
// sign-extended immediate of its format.
module decode_core
  import decode_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic [31:0]     instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opcode;
  logic [6:0]  func7;
  logic [2:0]  func3;
  fmt_t        fmt;
  logic        legal;
  ctrl_t       dec;
  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];

  // NOTE: every variable is given a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    dec   = '0;
    fmt   = FMT_R;
    legal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.wb_en = 1'b1;
        if (func7 == F7_ZERO)
          dec.alu_code = alu_code_of(func3, 1'b0);
        else if (func7 == F7_ALT && (func3 == 3'b000 || func3 == 3'b101))
          dec.alu_code = alu_code_of(func3, 1'b1);
        else
          legal = 1'b0;
      end
      OPC_OP_IMM: begin
        fmt              = FMT_I;
        dec.wb_en        = 1'b1;
        dec.alu_src2_sel = SRC2_IMM;
        dec.alu_code     = alu_code_of(func3, func3 == 3'b101 && func7 == F7_ALT);
        // Shift immediates reuse the upper immediate bits as a Func7 field.
        if (func3 == 3'b001)
          legal = (func7 == F7_ZERO);
        else if (func3 == 3'b101)
          legal = (func7 == F7_ZERO) || (func7 == F7_ALT);
      end
      OPC_LOAD: begin
        fmt              = FMT_I;
        dec.wb_en        = 1'b1;
        dec.alu_src2_sel = SRC2_IMM;
        dec.mem_out_sel  = WB_MEM;
        case (func3)
          3'b000:  dec.mem_rd_sel = RD_B;
          3'b001:  dec.mem_rd_sel = RD_H;
          3'b010:  dec.mem_rd_sel = RD_W;
          3'b100:  dec.mem_rd_sel = RD_BU;
          3'b101:  dec.mem_rd_sel = RD_HU;
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        fmt              = FMT_S;
        dec.alu_src2_sel = SRC2_IMM;
        case (func3)
          3'b000:  dec.mem_we = WR_B;
          3'b001:  dec.mem_we = WR_H;
          3'b010:  dec.mem_we = WR_W;
          default: legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        fmt          = FMT_B;
        dec.alu_code = {func3[1] ? SEL_UNS : SEL_NONE, ALU_COMP};
        case (func3)
          3'b000:         dec.if_branch = BR_EQ;
          3'b001:         dec.if_branch = BR_NE;
          3'b100, 3'b110: dec.if_branch = BR_LT;
          3'b101, 3'b111: dec.if_branch = BR_GE;
          default:        legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        fmt              = FMT_U;
        dec.wb_en        = 1'b1;
        dec.alu_src2_sel = SRC2_IMM;
        dec.mem_out_sel  = WB_IMM;
      end
      OPC_AUIPC: begin
        fmt              = FMT_U;
        dec.wb_en        = 1'b1;
        dec.alu_src1_sel = SRC1_PC;
        dec.alu_src2_sel = SRC2_IMM;
      end
      OPC_JAL: begin
        fmt              = FMT_J;
        dec.if_jump      = 1'b1;
        dec.wb_en        = 1'b1;
        dec.alu_src1_sel = SRC1_PC;
        dec.alu_src2_sel = SRC2_IMM;
        dec.mem_out_sel  = WB_PC4;
      end
      OPC_JALR: begin
        fmt              = FMT_I;
        dec.if_jump      = 1'b1;
        dec.wb_en        = 1'b1;
        dec.alu_src2_sel = SRC2_IMM;
        dec.mem_out_sel  = WB_PC4;
        legal            = (func3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase

    // An undecodable word becomes a NOP, flagged only when trapping is enabled.
    if (!legal) begin
      dec         = '0;
      fmt         = FMT_R;
      dec.illegal = ILLEGAL_TRAP;
    end
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    dec.rd  = instr[11:7];
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign ctrl = dec;
  assign imm  = XLEN'(signed'(imm32));

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: combinational RV32I decode followed by a two-entry
// skid buffer, so in_ready is a flop output independent of out_ready.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      if_branch,
  output logic            if_jump,
  output logic [4:0]      alu_code,
  output logic [1:0]      mem_we,
  output logic [2:0]      mem_rd_sel,
  output logic [1:0]      mem_out_sel,
  output logic            wb_en,
  output logic            alu_src1_sel,
  output logic            alu_src2_sel,
  output logic            illegal
);

  ctrl_t           dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  logic            main_valid, skid_valid;
  ctrl_t           main_ctrl, skid_ctrl;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic [XLEN-1:0] main_pc, skid_pc;

  logic take, accept;
  logic main_from_skid, main_from_in, skid_from_in;

  decode_core #(
    .XLEN         (XLEN),
    .ILLEGAL_TRAP (ILLEGAL_TRAP)
  ) u_core (
    .instr (instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  assign in_ready = !skid_valid;
  assign take     = main_valid && out_ready;
  assign accept   = in_valid && in_ready;

  // The skid entry is always older than any incoming word, so it refills main first.
  assign main_from_skid = take && skid_valid;
  assign main_from_in   = accept && (!main_valid || take);
  assign skid_from_in   = accept && main_valid && !take;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_from_skid || main_from_in || (main_valid && !take);
      skid_valid <= skid_from_in || (skid_valid && !take);
    end
  end

  // NOTE: the payload registers are reset as well, so a freshly reset stage
  // never presents a stale Illegal or Wb_en even though Out_valid masks them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_ctrl <= '0;
      main_imm  <= '0;
      main_pc   <= '0;
      skid_ctrl <= '0;
      skid_imm  <= '0;
      skid_pc   <= '0;
    end else if (!flush) begin
      if (main_from_skid) begin
        main_ctrl <= skid_ctrl;
        main_imm  <= skid_imm;
        main_pc   <= skid_pc;
      end else if (main_from_in) begin
        main_ctrl <= dec_ctrl;
        main_imm  <= dec_imm;
        main_pc   <= in_pc;
      end
      if (skid_from_in) begin
        skid_ctrl <= dec_ctrl;
        skid_imm  <= dec_imm;
        skid_pc   <= in_pc;
      end
    end
  end

  assign out_valid    = main_valid;
  assign out_pc       = main_pc;
  assign imm          = main_imm;
  assign rs1          = main_ctrl.rs1;
  assign rs2          = main_ctrl.rs2;
  assign rd           = main_ctrl.rd;
  assign if_branch    = main_ctrl.if_branch;
  assign if_jump      = main_ctrl.if_jump;
  assign alu_code     = main_ctrl.alu_code;
  assign mem_we       = main_ctrl.mem_we;
  assign mem_rd_sel   = main_ctrl.mem_rd_sel;
  assign mem_out_sel  = main_ctrl.mem_out_sel;
  assign wb_en        = main_ctrl.wb_en;
  assign alu_src1_sel = main_ctrl.alu_src1_sel;
  assign alu_src2_sel = main_ctrl.alu_src2_sel;
  assign illegal      = main_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles are queued when a word is
// accepted and compared when the stage hands one to execute.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [2:0]  br;
    logic        jump;
    logic [1:0]  we;
    logic        wb;
    logic        src2;
    logic        ill;
    logic        nt_wb;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n, in_valid, flush, out_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] in_pc;

  logic            in_ready, out_valid, if_jump, wb_en, alu_src1_sel, alu_src2_sel, illegal;
  logic [XLEN-1:0] out_pc, imm;
  logic [4:0]      rs1, rs2, rd, alu_code;
  logic [2:0]      if_branch, mem_rd_sel;
  logic [1:0]      mem_we, mem_out_sel;

  logic            nt_in_ready, nt_out_valid, nt_if_jump, nt_wb_en, nt_src1, nt_src2, nt_illegal;
  logic [XLEN-1:0] nt_out_pc, nt_imm;
  logic [4:0]      nt_rs1, nt_rs2, nt_rd, nt_alu_code;
  logic [2:0]      nt_if_branch, nt_mem_rd_sel;
  logic [1:0]      nt_mem_we, nt_mem_out_sel;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(XLEN), .ILLEGAL_TRAP(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .if_branch(if_branch), .if_jump(if_jump), .alu_code(alu_code),
    .mem_we(mem_we), .mem_rd_sel(mem_rd_sel), .mem_out_sel(mem_out_sel),
    .wb_en(wb_en), .alu_src1_sel(alu_src1_sel), .alu_src2_sel(alu_src2_sel),
    .illegal(illegal)
  );

  decode_stage #(.XLEN(XLEN), .ILLEGAL_TRAP(1'b0)) dut_nt (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(nt_in_ready),
    .instr(instr), .in_pc(in_pc), .flush(flush), .out_valid(nt_out_valid),
    .out_ready(out_ready), .out_pc(nt_out_pc), .rs1(nt_rs1), .rs2(nt_rs2), .rd(nt_rd),
    .imm(nt_imm), .if_branch(nt_if_branch), .if_jump(nt_if_jump), .alu_code(nt_alu_code),
    .mem_we(nt_mem_we), .mem_rd_sel(nt_mem_rd_sel), .mem_out_sel(nt_mem_out_sel),
    .wb_en(nt_wb_en), .alu_src1_sel(nt_src1), .alu_src2_sel(nt_src2),
    .illegal(nt_illegal)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [4:0] d, input logic [31:0] im, input logic [4:0] alu,
                              input logic [2:0] br, input logic jump, input logic [1:0] we,
                              input logic wb, input logic src2, input logic ill);
    exp_t e;
    e.pc = pc; e.rs1 = r1; e.rs2 = r2; e.rd = d; e.imm = im; e.alu = alu;
    e.br = br; e.jump = jump; e.we = we; e.wb = wb; e.src2 = src2; e.ill = ill;
    e.nt_wb = ill ? 1'b0 : wb;
    return e;
  endfunction

  // ADDI x<i>, x0, <i>
  function automatic logic [31:0] addi_word(input int i);
    return {7'b0, 5'(i), 5'd0, 3'b000, 5'(i), 7'b0010011};
  endfunction

  function automatic exp_t addi_exp(input int i, input logic [31:0] pc);
    return mk(pc, 5'd0, 5'(i), 5'(i), 32'(i), {SEL_NONE, ALU_ADD}, BR_NONE, 1'b0, WR_OFF,
              1'b1, 1'b1, 1'b0);
  endfunction

  task automatic compare(input exp_t e);
    check("out_pc", 64'(out_pc), 64'(e.pc));
    check("rs1", 64'(rs1), 64'(e.rs1));
    check("rs2", 64'(rs2), 64'(e.rs2));
    check("rd", 64'(rd), 64'(e.rd));
    check("wb_en", 64'(wb_en), 64'(e.wb));
    check("mem_we", 64'(mem_we), 64'(e.we));
    check("if_branch", 64'(if_branch), 64'(e.br));
    check("if_jump", 64'(if_jump), 64'(e.jump));
    check("illegal", 64'(illegal), 64'(e.ill));
    check("nt_illegal", 64'(nt_illegal), 64'(1'b0));
    check("nt_wb_en", 64'(nt_wb_en), 64'(e.nt_wb));
    if (!e.ill) begin
      check("imm", 64'(imm), 64'(e.imm));
      check("alu_code", 64'(alu_code), 64'(e.alu));
      check("alu_src2_sel", 64'(alu_src2_sel), 64'(e.src2));
    end
  endtask

  task automatic offer(input logic [31:0] word, input exp_t e);
    in_valid = 1'b1;
    instr    = word;
    in_pc    = e.pc;
    cur      = e;
  endtask

  // One clock: sample at the falling edge, update the scoreboard, cross the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("in_ready", 64'(in_ready), 64'(sb.size() < 2));
    if (flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        compare(e);
      end
      if (in_valid && in_ready) sb.push_back(cur);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    in_pc     = '0;
    cur       = addi_exp(0, 32'h0);

    // Reset state
    #12;
    check("reset_out_valid", 64'(out_valid), 64'(1'b0));
    check("reset_illegal", 64'(illegal), 64'(1'b0));
    check("reset_wb_en", 64'(wb_en), 64'(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'(1'b1));

    // Directed decode, one word per cycle
    offer(32'h002081B3, mk(32'h100, 5'd1, 5'd2, 5'd3, 32'h0, {SEL_NONE, ALU_ADD},
                           BR_NONE, 1'b0, WR_OFF, 1'b1, 1'b0, 1'b0));
    step();
    offer(32'h402081B3, mk(32'h104, 5'd1, 5'd2, 5'd3, 32'h0, {SEL_NEG_B, ALU_ADD},
                           BR_NONE, 1'b0, WR_OFF, 1'b1, 1'b0, 1'b0));
    step();
    offer(32'hFE006E63, mk(32'h108, 5'd0, 5'd0, 5'd28, 32'hFFFFF7FC, {SEL_UNS, ALU_COMP},
                           BR_LT, 1'b0, WR_OFF, 1'b0, 1'b0, 1'b0));
    step();
    offer(32'hFE000EE3, mk(32'h10C, 5'd0, 5'd0, 5'd29, 32'hFFFFFFFC, {SEL_NONE, ALU_COMP},
                           BR_EQ, 1'b0, WR_OFF, 1'b0, 1'b0, 1'b0));
    step();
    offer(32'hFE512C23, mk(32'h110, 5'd2, 5'd5, 5'd24, 32'hFFFFFFF8, {SEL_NONE, ALU_ADD},
                           BR_NONE, 1'b0, WR_W, 1'b0, 1'b1, 1'b0));
    step();
    offer(32'h123453B7, mk(32'h114, 5'd8, 5'd3, 5'd7, 32'h12345000, {SEL_NONE, ALU_ADD},
                           BR_NONE, 1'b0, WR_OFF, 1'b1, 1'b1, 1'b0));
    step();
    offer(32'hFFDFF0EF, mk(32'h118, 5'd31, 5'd29, 5'd1, 32'hFFFFFFFC, {SEL_NONE, ALU_ADD},
                           BR_NONE, 1'b1, WR_OFF, 1'b1, 1'b1, 1'b0));
    step();
    offer(32'h4040D193, mk(32'h11C, 5'd1, 5'd4, 5'd3, 32'h00000404, {SEL_ARITH, ALU_SR},
                           BR_NONE, 1'b0, WR_OFF, 1'b1, 1'b1, 1'b0));
    step();
    offer(32'h02009193, mk(32'h120, 5'd1, 5'd0, 5'd3, 32'h0, 5'd0,
                           BR_NONE, 1'b0, WR_OFF, 1'b0, 1'b0, 1'b1));
    step();
    offer(32'h00000000, mk(32'h124, 5'd0, 5'd0, 5'd0, 32'h0, 5'd0,
                           BR_NONE, 1'b0, WR_OFF, 1'b0, 1'b0, 1'b1));
    step();
    in_valid = 1'b0;
    step();
    step();

    // Backpressure: three words offered while execute stalls
    out_ready = 1'b0;
    offer(addi_word(1), addi_exp(1, 32'h200));
    step();
    offer(addi_word(2), addi_exp(2, 32'h204));
    step();
    offer(addi_word(3), addi_exp(3, 32'h208));
    step();
    check("stall_in_ready_low", 64'(in_ready), 64'(1'b0));
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    step();

    // Full throughput
    for (int i = 4; i < 12; i++) begin
      offer(addi_word(i), addi_exp(i, 32'h300 + 32'(i) * 4));
      step();
    end
    in_valid = 1'b0;
    step();
    step();

    // Flush with both entries held and a word arriving
    out_ready = 1'b0;
    offer(addi_word(20), addi_exp(20, 32'h400));
    step();
    offer(addi_word(21), addi_exp(21, 32'h404));
    step();
    offer(addi_word(22), addi_exp(22, 32'h408));
    flush = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("flush_out_valid", 64'(out_valid), 64'(1'b0));
    check("flush_in_ready", 64'(in_ready), 64'(1'b1));
    step();
    step();
    offer(addi_word(23), addi_exp(23, 32'h40C));
    step();
    in_valid = 1'b0;
    step();
    step();

    // Asynchronous reset while a word is held
    out_ready = 1'b0;
    offer(addi_word(24), addi_exp(24, 32'h500));
    step();
    in_valid = 1'b0;
    check("held_out_valid", 64'(out_valid), 64'(1'b1));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_out_valid", 64'(out_valid), 64'(1'b0));
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rerelease_in_ready", 64'(in_ready), 64'(1'b1));
    out_ready = 1'b1;
    offer(addi_word(25), addi_exp(25, 32'h600));
    step();
    in_valid = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
